// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: controller states and
// helpers that derive the slice count and slice-index width from WIDTH/DIGIT.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Narrowest legal slice-index register, even when there is only one slice.
    localparam int MIN_IDX_W = 1;

    // Number of DIGIT-bit slices needed to cover a WIDTH-bit operand.
    function automatic int num_slices(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of the slice-index register: clog2 of the slice count, at least 1.
    function automatic int slice_idx_w(input int width, input int digit);
        int n;
        n = width / digit;
        return ($clog2(n) < MIN_IDX_W) ? MIN_IDX_W : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_digit_slice.sv
// One DIGIT-bit slice of the subtractor: a ripple of full adders computing
// x + ~y + cin, so a chain of slices fed with carry-in 1 yields x - y.
module sub_digit_slice
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x_i,
    input  logic [DIGIT-1:0] y_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o
);

    logic [DIGIT:0] carry;

    // Ripple the carry through the slice, inverting the subtrahend bits.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            sum_o[i]     = x_i[i] ^ ~y_i[i] ^ carry[i];
            carry[i + 1] = (x_i[i] & ~y_i[i]) | (x_i[i] & carry[i]) | (~y_i[i] & carry[i]);
        end
        cout_o = carry[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A-B subtractor (credit minus price) with valid/ready handshakes.
// One DIGIT-bit slice is processed per cycle, LSB slice first, with the borrow
// chain held in a carry register between cycles.
// Optional feature: define SUB_SATURATE_EN to clamp diff to 0 whenever a < b.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int N    = num_slices(WIDTH, DIGIT);
    localparam int IDXW = slice_idx_w(WIDTH, DIGIT);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if (WIDTH % DIGIT != 0) begin : gBadDigit
        $fatal(1, "serial_subtractor: DIGIT must divide WIDTH");
    end

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] opA_q,      opA_d;
    logic [WIDTH-1:0] opB_q,      opB_d;
    logic [IDXW-1:0]  sliceIdx_q, sliceIdx_d;
    logic             carry_q,    carry_d;
    logic [WIDTH-1:0] diff_q,     diff_d;
    logic             bout_q,     bout_d;
    logic             inReady_q,  inReady_d;

    logic [DIGIT-1:0] sliceA;
    logic [DIGIT-1:0] sliceB;
    logic [DIGIT-1:0] sliceSum;
    logic             sliceCout;

    assign sliceA = DIGIT'(opA_q >> (DIGIT * sliceIdx_q));
    assign sliceB = DIGIT'(opB_q >> (DIGIT * sliceIdx_q));

    sub_digit_slice #(
        .DIGIT (DIGIT)
    ) uSlice (
        .x_i    (sliceA),
        .y_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // Next-state logic: accept operands, walk the slices, then hold the result.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        sliceIdx_d = sliceIdx_q;
        carry_d    = carry_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid && inReady_q) begin
                    opA_d      = a;
                    opB_d      = b;
                    sliceIdx_d = '0;
                    carry_d    = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                for (int s = 0; s < N; s++) begin
                    if (sliceIdx_q == IDXW'(s)) begin
                        diff_d[s*DIGIT +: DIGIT] = sliceSum;
                    end
                end
                carry_d    = sliceCout;
                sliceIdx_d = sliceIdx_q + 1'b1;
                if (sliceIdx_q == LAST_IDX) begin
                    bout_d  = ~sliceCout;
`ifdef SUB_SATURATE_EN
                    if (!sliceCout) begin
                        diff_d = '0;
                    end
`else
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        inReady_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            sliceIdx_q <= '0;
            carry_q    <= 1'b1;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            inReady_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            sliceIdx_q <= sliceIdx_d;
            carry_q    <= carry_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            inReady_q  <= inReady_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a WIDTH=8/DIGIT=2 instance driven
// through a scoreboard queue, plus a single-pass DIGIT=8 instance.
// Expected results honour SUB_SATURATE_EN when it is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid;
    logic       inReady;
    logic [7:0] a;
    logic [7:0] b;
    logic       outValid;
    logic       outReady;
    logic [7:0] diff;
    logic       bout;

    logic       spInValid;
    logic       spInReady;
    logic [7:0] spA;
    logic [7:0] spB;
    logic       spOutValid;
    logic       spOutReady;
    logic [7:0] spDiff;
    logic       spBout;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [8:0] expQ[$];

    always #5 clk = ~clk;

    serial_subtractor #(
        .WIDTH (8),
        .DIGIT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (a),
        .b         (b),
        .out_valid (outValid),
        .out_ready (outReady),
        .diff      (diff),
        .bout      (bout)
    );

    serial_subtractor #(
        .WIDTH (8),
        .DIGIT (8)
    ) dutSp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (spInValid),
        .in_ready  (spInReady),
        .a         (spA),
        .b         (spB),
        .out_valid (spOutValid),
        .out_ready (spOutReady),
        .diff      (spDiff),
        .bout      (spBout)
    );

    // Reference result {borrow, difference} for an 8-bit unsigned subtraction.
    function automatic logic [8:0] modelSub(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        logic       br;
        br = (x < y);
        d  = x - y;
`ifdef SUB_SATURATE_EN
        if (br) d = 8'd0;
`else
`endif
        return {br, d};
    endfunction

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Run one operation on the DIGIT=2 instance; called and returns at a negedge.
    task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                                 input int holdCycles, input bit earlyReady);
        int         cyc;
        logic [8:0] expRes;
        logic [7:0] heldDiff;
        logic       heldBout;
        outReady = earlyReady;
        cyc = 0;
        while (!inReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("inReadyBeforeAccept", 32'(inReady), 1);
        a       = aIn;
        b       = bIn;
        inValid = 1'b1;
        expQ.push_back(modelSub(aIn, bIn));
        @(negedge clk);
        inValid = 1'b0;
        a       = 8'($urandom);
        b       = 8'($urandom);
        checkOutput("busyInRun", 32'(inReady), 0);
        cyc = 0;
        while (!outValid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 4);
        expRes = expQ.pop_front();
        checkOutput("diff", 32'(diff), 32'(expRes[7:0]));
        checkOutput("bout", 32'(bout), 32'(expRes[8]));
        heldDiff = diff;
        heldBout = bout;
        for (int i = 0; i < holdCycles; i++) begin
            inValid = 1'b1;
            a       = 8'($urandom);
            b       = 8'($urandom);
            @(negedge clk);
            checkOutput("holdDiff", 32'(diff), 32'(heldDiff));
            checkOutput("holdBout", 32'(bout), 32'(heldBout));
            checkOutput("holdOutValid", 32'(outValid), 1);
            checkOutput("holdInReady", 32'(inReady), 0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("postHsOutValid", 32'(outValid), 0);
        checkOutput("postHsInReady", 32'(inReady), 1);
        checkOutput("idleDiffHold", 32'(diff), 32'(heldDiff));
        outReady = 1'b0;
    endtask

    // Main sequence: reset, directed cases, reset abort, single-pass, random ops.
    initial begin
        logic [8:0] spExp;
        int         staleCount;
        rst_n      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b0;
        a          = '0;
        b          = '0;
        spInValid  = 1'b0;
        spOutReady = 1'b0;
        spA        = '0;
        spB        = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstInReady", 32'(inReady), 0);
        checkOutput("rstOutValid", 32'(outValid), 0);
        checkOutput("rstDiff", 32'(diff), 0);
        checkOutput("rstBout", 32'(bout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstInReady", 32'(inReady), 1);

        applyStimulus(8'd200, 8'd75, 0, 1'b0);
        applyStimulus(8'd10, 8'd20, 3, 1'b0);
        applyStimulus(8'h55, 8'h55, 0, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1, 1'b0);

        a       = 8'd200;
        b       = 8'd75;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abortOutValid", 32'(outValid), 0);
        checkOutput("abortDiff", 32'(diff), 0);
        checkOutput("abortBout", 32'(bout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abortInReady", 32'(inReady), 1);
        staleCount = 0;
        for (int i = 0; i < 8; i++) begin
            if (outValid) staleCount++;
            @(negedge clk);
        end
        checkOutput("abortNoStale", 32'(staleCount), 0);

        checkOutput("spInReady", 32'(spInReady), 1);
        spA       = 8'd1;
        spB       = 8'd2;
        spInValid = 1'b1;
        spExp     = modelSub(8'd1, 8'd2);
        @(negedge clk);
        spInValid = 1'b0;
        checkOutput("spNotYetValid", 32'(spOutValid), 0);
        @(negedge clk);
        checkOutput("spLatency", 32'(spOutValid), 1);
        checkOutput("spDiff", 32'(spDiff), 32'(spExp[7:0]));
        checkOutput("spBout", 32'(spBout), 32'(spExp[8]));
        spOutReady = 1'b1;
        @(negedge clk);
        checkOutput("spPostHsOutValid", 32'(spOutValid), 0);
        checkOutput("spPostHsInReady", 32'(spInReady), 1);
        spOutReady = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bit early;
            early = ($urandom_range(0, 1) == 1);
            applyStimulus(8'($urandom), 8'($urandom), early ? 0 : int'($urandom_range(0, 2)), early);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global time bound so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
